// File: rtl/uart_frame_assembler.sv
// -----------------------------------------------------------------------------
// uart_frame_assembler
//
// Collects bytes from a UART receiver into fixed-size image frames. A frame is
// one HEADER byte followed by IMG_BYTES payload bytes, which are written into
// an internal buffer. A completed frame is held (o_frame_valid) until the
// downstream consumer acknowledges it; while held, incoming bytes are dropped
// and flagged with o_overrun. A stalled frame is aborted after TIMEOUT_CLKS
// idle clocks and flagged with o_frame_err.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous reset, active-high
//   i_rx_dv        one-cycle strobe, i_rx_byte is valid
//   i_rx_byte      received byte
//   i_frame_ack    consumer releases the buffer (only honoured while held)
//   i_rd_addr      buffer read address
//   o_rd_data      buffer[i_rd_addr], one clock of latency
//   o_frame_valid  level, a complete frame is held in the buffer
//   o_frame_err    one-cycle pulse, frame aborted by timeout
//   o_overrun      one-cycle pulse, byte dropped because the buffer is held
//   o_busy         high while a frame is being received
//   o_byte_cnt     payload bytes stored in the current frame
// -----------------------------------------------------------------------------
module uart_frame_assembler #(
  parameter logic [7:0] HEADER       = 8'hAA,
  parameter int         IMG_BYTES    = 32,
  parameter int         TIMEOUT_CLKS = 2000,
  parameter int         AW           = $clog2(IMG_BYTES)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_rx_dv,
  input  logic [7:0]    i_rx_byte,
  input  logic          i_frame_ack,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_frame_valid,
  output logic          o_frame_err,
  output logic          o_overrun,
  output logic          o_busy,
  output logic [AW:0]   o_byte_cnt
);

  localparam int TW    = $clog2(TIMEOUT_CLKS + 1);
  localparam int DEPTH = 1 << AW;

  // Count value held when the final payload byte arrives.
  localparam logic [AW:0] LP_LAST_IDX = (AW+1)'(IMG_BYTES - 1);

  // The timeout counter is cleared on the strobe edge and counts idle edges
  // after it. Firing on the edge that sees TIMEOUT_CLKS-2 places the error
  // pulse in the TIMEOUT_CLKS-th cycle after the last strobe, and IDLE is
  // entered on that same edge.
  localparam logic [TW-1:0] LP_TMO_FIRE = TW'(TIMEOUT_CLKS - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW:0]   r_byte_cnt;
  logic [AW:0]   w_byte_cnt_next;
  logic [TW-1:0] r_tmo;
  logic [TW-1:0] w_tmo_next;
  logic          r_frame_err;
  logic          w_frame_err_next;
  logic          r_overrun;
  logic          w_overrun_next;
  logic          r_busy;
  logic          r_frame_valid;
  logic          w_wr_en;
  logic [7:0]    r_rd_data;

  // Payload buffer: plain array with registered read so it maps onto block RAM.
  // Contents are intentionally left uninitialised and survive reset.
  logic [7:0] r_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_byte_cnt_next  = r_byte_cnt;
    w_tmo_next       = r_tmo;
    w_frame_err_next = 1'b0;
    w_overrun_next   = 1'b0;
    w_wr_en          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_rx_dv && (i_rx_byte == HEADER)) begin
          w_state_next    = S_RECV;
          w_byte_cnt_next = '0;
          w_tmo_next      = '0;
        end
      end

      S_RECV: begin
        if (i_rx_dv) begin
          // Header-valued bytes are ordinary payload here; no resync.
          w_wr_en         = 1'b1;
          w_byte_cnt_next = r_byte_cnt + 1'b1;
          w_tmo_next      = '0;
          if (r_byte_cnt == LP_LAST_IDX) begin
            w_state_next = S_DONE;
          end
        end else if (r_tmo == LP_TMO_FIRE) begin
          w_frame_err_next = 1'b1;
          w_byte_cnt_next  = '0;
          w_tmo_next       = '0;
          w_state_next     = S_IDLE;
        end else begin
          w_tmo_next = r_tmo + 1'b1;
        end
      end

      S_DONE: begin
        // A byte arriving together with the ack is still dropped: the buffer
        // belongs to the consumer until the edge that takes the ack.
        if (i_rx_dv) begin
          w_overrun_next = 1'b1;
        end
        if (i_frame_ack) begin
          w_state_next    = S_IDLE;
          w_byte_cnt_next = '0;
        end
      end

      default: begin
        w_state_next    = S_IDLE;
        w_byte_cnt_next = '0;
        w_tmo_next      = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_byte_cnt    <= '0;
      r_tmo         <= '0;
      r_frame_err   <= 1'b0;
      r_overrun     <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_valid <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_byte_cnt    <= w_byte_cnt_next;
      r_tmo         <= w_tmo_next;
      r_frame_err   <= w_frame_err_next;
      r_overrun     <= w_overrun_next;
      r_busy        <= (w_state_next == S_RECV);
      r_frame_valid <= (w_state_next == S_DONE);
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer write and read ports
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_byte_cnt[AW-1:0]] <= i_rx_byte;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data     = r_rd_data;
  assign o_frame_valid = r_frame_valid;
  assign o_frame_err   = r_frame_err;
  assign o_overrun     = r_overrun;
  assign o_busy        = r_busy;
  assign o_byte_cnt    = r_byte_cnt;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_assembler
//
// Stimulus tasks drive bytes, acks, reads and resets, update a frame-level
// reference model and push the expected responses (pulse times, frame
// completion, read data, status snapshots) into queues, each stamped with the
// clock edge after which it must be visible. An independent monitor samples
// the DUT on every falling edge and retires queue entries as the DUT presents
// the matching output.
// -----------------------------------------------------------------------------
module tb_uart_frame_assembler;

  localparam logic [7:0] HDR = 8'hAA;
  localparam int         IMG = 32;
  localparam int         TMO = 2000;
  localparam int         AW  = $clog2(IMG);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_dv = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          frame_ack = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic          frame_valid;
  logic          frame_err;
  logic          overrun;
  logic          busy;
  logic [AW:0]   byte_cnt;

  uart_frame_assembler #(
    .HEADER      (HDR),
    .IMG_BYTES   (IMG),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx_dv      (rx_dv),
    .i_rx_byte    (rx_byte),
    .i_frame_ack  (frame_ack),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_frame_valid(frame_valid),
    .o_frame_err  (frame_err),
    .o_overrun    (overrun),
    .o_busy       (busy),
    .o_byte_cnt   (byte_cnt)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; read on falling edges only.
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard queues
  // ---------------------------------------------------------------------------
  typedef struct {
    int            stamp;
    logic [AW-1:0] addr;
    logic [7:0]    exp;
  } rd_t;

  typedef struct {
    int stamp;
    bit busy;
    bit valid;
    int cnt;
    bit chk_rd;
  } st_t;

  int  ovr_q[$];
  int  err_q[$];
  int  frm_q[$];
  rd_t rd_q[$];
  st_t st_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0h, required %0h", name, edge_n, act, exp);
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: where the frame stands, described by the byte rules
  // ---------------------------------------------------------------------------
  bit         m_recv  = 1'b0;  // header seen, payload being collected
  bit         m_held  = 1'b0;  // full frame waiting for the consumer
  int         m_count = 0;     // payload bytes collected so far
  int         m_last  = 0;     // edge of the most recent accepted byte
  logic [7:0] m_buf [IMG];

  function automatic void model_byte(logic [7:0] b, int e);
    if (m_held) begin
      ovr_q.push_back(e);
    end else if (m_recv) begin
      m_buf[m_count] = b;
      m_count++;
      m_last = e;
      if (m_count == IMG) begin
        m_recv = 1'b0;
        m_held = 1'b1;
        frm_q.push_back(e);
      end
    end else if (b == HDR) begin
      m_recv  = 1'b1;
      m_count = 0;
      m_last  = e;
    end
  endfunction

  function automatic void push_status(int e, bit chk_rd);
    st_t s;
    s.stamp  = e;
    s.busy   = m_recv;
    s.valid  = m_held;
    s.cnt    = m_held ? IMG : (m_recv ? m_count : 0);
    s.chk_rd = chk_rd;
    st_q.push_back(s);
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  bit   mon_en = 1'b0;
  logic prev_valid = 1'b0;
  rd_t  mon_r;
  st_t  mon_s;

  always @(negedge clk) begin
    if (mon_en) begin
      if (overrun === 1'b1) begin
        if (ovr_q.size() == 0) chk("overrun_unexpected", 32'(overrun), 32'd0);
        else                   chk("overrun_edge", edge_n, ovr_q.pop_front());
      end else if (ovr_q.size() > 0 && ovr_q[0] < edge_n) begin
        chk("overrun_missing", edge_n, ovr_q.pop_front());
      end

      if (frame_err === 1'b1) begin
        if (err_q.size() == 0) chk("frame_err_unexpected", 32'(frame_err), 32'd0);
        else                   chk("frame_err_edge", edge_n, err_q.pop_front());
      end else if (err_q.size() > 0 && err_q[0] < edge_n) begin
        chk("frame_err_missing", edge_n, err_q.pop_front());
      end

      if (frame_valid === 1'b1 && prev_valid !== 1'b1) begin
        if (frm_q.size() == 0) begin
          chk("frame_valid_unexpected", 32'(frame_valid), 32'd0);
        end else begin
          chk("frame_valid_edge", edge_n, frm_q.pop_front());
          chk("frame_byte_cnt", 32'(byte_cnt), IMG);
        end
      end else if (frm_q.size() > 0 && frm_q[0] < edge_n) begin
        chk("frame_valid_missing", edge_n, frm_q.pop_front());
      end

      while (rd_q.size() > 0 && rd_q[0].stamp <= edge_n) begin
        mon_r = rd_q.pop_front();
        chk($sformatf("rd_data[%0d]", mon_r.addr), 32'(rd_data), 32'(mon_r.exp));
      end

      while (st_q.size() > 0 && st_q[0].stamp <= edge_n) begin
        mon_s = st_q.pop_front();
        chk("busy", 32'(busy), 32'(mon_s.busy));
        chk("frame_valid", 32'(frame_valid), 32'(mon_s.valid));
        chk("byte_cnt", 32'(byte_cnt), mon_s.cnt);
        if (mon_s.chk_rd) chk("rd_data_reset", 32'(rd_data), 32'd0);
      end
    end
    prev_valid = frame_valid;
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks; each starts and ends just after a falling edge
  // ---------------------------------------------------------------------------
  task automatic send(input logic [7:0] b, input int gap);
    int e;
    rx_dv   = 1'b1;
    rx_byte = b;
    e = edge_n + 1;
    model_byte(b, e);
    push_status(e, 1'b0);
    @(negedge clk);
    rx_dv = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d [IMG]);
    send(HDR, int'($urandom_range(0, 8)));
    for (int i = 0; i < IMG; i++) send(d[i], int'($urandom_range(0, 8)));
  endtask

  task automatic do_ack(input bit with_byte, input logic [7:0] b);
    int e;
    bit was_held;
    was_held  = m_held;
    frame_ack = 1'b1;
    e = edge_n + 1;
    if (with_byte) begin
      rx_dv   = 1'b1;
      rx_byte = b;
      model_byte(b, e);
    end
    if (was_held) begin
      m_held  = 1'b0;
      m_count = 0;
    end
    push_status(e, 1'b0);
    @(negedge clk);
    frame_ack = 1'b0;
    rx_dv     = 1'b0;
  endtask

  task automatic do_reset();
    int e;
    rst = 1'b1;
    e = edge_n + 1;
    m_recv  = 1'b0;
    m_held  = 1'b0;
    m_count = 0;
    push_status(e, 1'b1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rd(input int addr);
    rd_t r;
    rd_addr = AW'(addr);
    r.stamp = edge_n + 1;
    r.addr  = AW'(addr);
    r.exp   = m_buf[addr];
    rd_q.push_back(r);
    @(negedge clk);
  endtask

  // Leave the line idle; the abort is due TMO cycles after the last byte.
  task automatic wait_timeout();
    int e;
    e = m_last + TMO - 1;
    err_q.push_back(e);
    m_recv  = 1'b0;
    m_count = 0;
    push_status(e, 1'b0);
    while (edge_n < e + 2) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  logic [7:0] nom [IMG];
  logic [7:0] rnd [IMG];

  initial begin
    for (int i = 0; i < IMG; i++) nom[i] = (i == 10) ? 8'h20 : 8'h00;

    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    do_reset();
    repeat (2) @(negedge clk);

    // 1: nominal frame
    send_frame(nom);
    rd(10); rd(9); rd(31);
    do_ack(1'b0, 8'h00);
    repeat (2) @(negedge clk);

    // 2: leading garbage before the frame
    send(8'h55, 3); send(8'h00, 0); send(8'h13, 5);
    send_frame(nom);
    rd(10); rd(9); rd(31); rd(0);
    do_ack(1'b0, 8'h00);

    // 3: timeout after 10 payload bytes, then a normal random frame
    send(HDR, 2);
    for (int i = 0; i < 10; i++) send(8'($urandom_range(0, 255)), int'($urandom_range(0, 8)));
    wait_timeout();
    for (int i = 0; i < IMG; i++) rnd[i] = 8'($urandom_range(0, 255));
    send_frame(rnd);
    for (int i = 0; i < IMG; i++) rd(i);
    do_ack(1'b0, 8'h00);

    // 4: overrun while held, ack, then ack coinciding with a strobe
    send_frame(nom);
    send(HDR, 1);
    for (int i = 0; i < 5; i++) send(8'hFF, int'($urandom_range(0, 3)));
    rd(10); rd(11);
    do_ack(1'b0, 8'h00);
    send_frame(nom);
    do_ack(1'b1, 8'h33);
    send(HDR, 0);  // header on the cycle right after the ack
    for (int i = 0; i < IMG; i++) send(8'($urandom_range(0, 255)), 0);
    rd(5);
    do_ack(1'b0, 8'h00);

    // 5: reset in the middle of a frame
    send(HDR, 1);
    for (int i = 0; i < 20; i++) send(8'($urandom_range(0, 255)), int'($urandom_range(0, 4)));
    do_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < IMG; i++) rnd[i] = 8'($urandom_range(0, 255));
    send_frame(rnd);
    for (int i = 0; i < IMG; i++) rd(i);
    do_ack(1'b0, 8'h00);

    // 6: header value inside the payload
    for (int i = 0; i < IMG; i++) rnd[i] = 8'($urandom_range(0, 255));
    rnd[0]       = HDR;
    rnd[IMG - 1] = 8'h7E;
    send_frame(rnd);
    rd(0); rd(IMG - 1);
    send(8'h01, 2);
    do_ack(1'b0, 8'h00);

    // Random traffic: headers, payload, overruns, acks and reads
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (m_held && r < 12)      do_ack(r < 4, 8'($urandom_range(0, 255)));
      else if (m_held && r < 35) rd(int'($urandom_range(0, IMG - 1)));
      else send((r % 6 == 0) ? HDR : 8'($urandom_range(0, 255)), int'($urandom_range(0, 6)));
    end
    if (m_held) do_ack(1'b0, 8'h00);

    repeat (6) @(negedge clk);
    chk("queues_drained",
        ovr_q.size() + err_q.size() + frm_q.size() + rd_q.size() + st_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
